// File: rtl/apb_regspace_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regspace_bridge
//  Description : APB3 completer that converts each APB transfer into a single
//                register-space transaction toward one register bank. Writes
//                use the bank's wreq valid/ready handshake. Reads use the
//                rreq request plus the rack acknowledge handshake. Only one
//                transfer is in flight at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro : REGSPACE_BRIDGE_TIMEOUT_EN
//    defined   - a bank handshake that stays pending for TIMEOUT cycles is
//                abandoned. The bridge then completes the APB transfer with
//                pslverr=1, and with prdata=0 for a read.
//    undefined - the bridge waits indefinitely. pslverr is constant 0.
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          : clock, asynchronous active-low reset
//    psel_i .. pwdata_i  : APB request (setup/access phase, byte address)
//    pready_o, prdata_o,
//    pslverr_o           : APB completion, read data and error
//    rreq_*_o, rreq_rdy_i: read request toward the bank (word address)
//    rack_*_i, rack_rdy_o: read acknowledge from the bank
//    wreq_*_o, wreq_rdy_i: write request toward the bank (word address, data)
// ============================================================================
module apb_regspace_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // APB completer
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W+1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic              pready_o,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pslverr_o,
    // Register-space read request / acknowledge
    output logic [ADDR_W-1:0] rreq_addr_o,
    output logic              rreq_vld_o,
    input  logic              rreq_rdy_i,
    input  logic [DATA_W-1:0] rack_data_i,
    input  logic              rack_vld_i,
    output logic              rack_rdy_o,
    // Register-space write request
    output logic [ADDR_W-1:0] wreq_addr_o,
    output logic [DATA_W-1:0] wreq_data_o,
    output logic              wreq_vld_o,
    input  logic              wreq_rdy_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] prdata_q,  prdata_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;
    logic              wvld_q,    wvld_d;
    logic              rvld_q,    rvld_d;     // drives both rreq_vld and rack_rdy

    logic              w_timeout;

    // Completion of a read depends only on the acknowledge. rreq_rdy is
    // normally seen in the same cycle, but it is not needed for completion.
    // The byte-lane bits of paddr are dropped.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{rreq_rdy_i, paddr_i[1:0]};

`ifdef REGSPACE_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] w_cnt_inc;

    // cnt_q holds the number of cycles already spent waiting. The abort
    // fires on the edge that would make the count equal TIMEOUT, so the
    // request stays valid for exactly TIMEOUT cycles.
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_timeout = (w_cnt_inc == C_TIMEOUT);

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_WRITE) || (state_q == S_READ)) begin
            cnt_d = w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int C_UNUSED_TIMEOUT = TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wvld_d    = wvld_q;
        rvld_d    = rvld_q;

        case (state_q)
            S_IDLE: begin
                // Only a setup phase seen here starts a transfer. Setups
                // seen in any other state are ignored.
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i[ADDR_W+1:2];
                    wdata_d = pwdata_i;
                    if (pwrite_i) begin
                        wvld_d  = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        rvld_d  = 1'b1;
                        state_d = S_READ;
                    end
                end
            end

            S_WRITE: begin
                // A handshake wins over a timeout that expires in the same cycle.
                if (wvld_q && wreq_rdy_i) begin
                    wvld_d   = 1'b0;
                    pready_d = 1'b1;
                    state_d  = S_RESP;
                end else if (w_timeout) begin
                    wvld_d    = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = S_RESP;
                end
            end

            S_READ: begin
                if (rvld_q && rack_vld_i) begin
                    prdata_d = rack_data_i;
                    rvld_d   = 1'b0;
                    pready_d = 1'b1;
                    state_d  = S_RESP;
                end else if (w_timeout) begin
                    prdata_d  = '0;
                    rvld_d    = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                // pready_d defaults to 0, so pready is high for one cycle only.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                wvld_d  = 1'b0;
                rvld_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wvld_q    <= 1'b0;
            rvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wvld_q    <= wvld_d;
            rvld_q    <= rvld_d;
        end
    end

    assign pready_o    = pready_q;
    assign prdata_o    = prdata_q;
    assign pslverr_o   = pslverr_q;
    assign rreq_addr_o = addr_q;
    assign rreq_vld_o  = rvld_q;
    assign rack_rdy_o  = rvld_q;
    assign wreq_addr_o = addr_q;
    assign wreq_data_o = wdata_q;
    assign wreq_vld_o  = wvld_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_regspace_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_regspace_bridge
//  Description : Self-checking bench for apb_regspace_bridge. The bench acts as
//                both the APB requester and the register bank. The bank is an
//                associative-array memory, and every expected value is derived
//                from that memory and from the APB transfer rules.
//                REGSPACE_BRIDGE_TIMEOUT_EN enables the timeout scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regspace_bridge;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W+1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic              pready, pslverr;
    logic [DATA_W-1:0] prdata;
    logic [ADDR_W-1:0] rreq_addr, wreq_addr;
    logic              rreq_vld, rack_rdy, wreq_vld;
    logic              rreq_rdy = 1'b0, rack_vld = 1'b0, wreq_rdy = 1'b0;
    logic [DATA_W-1:0] rack_data = '0;
    logic [DATA_W-1:0] wreq_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bank contents and the prdata value APB should see.
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_prdata = '0;

    apb_regspace_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .pwdata_i   (pwdata),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .rreq_addr_o(rreq_addr),
        .rreq_vld_o (rreq_vld),
        .rreq_rdy_i (rreq_rdy),
        .rack_data_i(rack_data),
        .rack_vld_i (rack_vld),
        .rack_rdy_o (rack_rdy),
        .wreq_addr_o(wreq_addr),
        .wreq_data_o(wreq_data),
        .wreq_vld_o (wreq_vld),
        .wreq_rdy_i (wreq_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] bank_word(input logic [ADDR_W-1:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // One complete APB transfer. The bank answers after wait_n stall cycles.
    // The call returns at mid-cycle of the RESP cycle, so the next call's
    // setup phase lands in the cycle right after RESP.
    task automatic apb_xfer(input bit wr, input logic [ADDR_W+1:0] a,
                            input logic [DATA_W-1:0] d, input int wait_n);
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] rv;
        wa = a[ADDR_W+1:2];
        rv = '0;
        @(negedge clk);
        chk("idle_pready", pready, 1'b0);
        chk("idle_vld", {wreq_vld, rreq_vld, rack_rdy}, 3'b000);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        // Scramble address/data so that only the captured setup values can match.
        penable = 1'b1; paddr = ADDR_W'($urandom); pwdata = $urandom;
        if (!wr) rv = bank_word(wa);
        for (int c = 0; c <= wait_n; c++) begin
            if (wr) begin
                chk("wreq_vld", wreq_vld, 1'b1);
                chk("wreq_addr", wreq_addr, wa);
                chk("wreq_data", wreq_data, d);
                chk("rreq_vld_off", {rreq_vld, rack_rdy}, 2'b00);
            end else begin
                chk("rreq_vld_rack_rdy", {rreq_vld, rack_rdy}, 2'b11);
                chk("rreq_addr", rreq_addr, wa);
                chk("wreq_vld_off", wreq_vld, 1'b0);
            end
            chk("pready_wait", pready, 1'b0);
            chk("prdata_hold", prdata, exp_prdata);
            wreq_rdy  = wr && (c == wait_n);
            rack_vld  = !wr && (c == wait_n);
            rack_data = rack_vld ? rv : DATA_W'($urandom);
            rreq_rdy  = 1'($urandom % 2);
            // Occasional stray setup phase mid-transfer; the bridge must ignore it.
            penable   = !((c > 0) && ($urandom % 4 == 0));
            @(negedge clk);
        end
        wreq_rdy = 1'b0; rack_vld = 1'b0; rreq_rdy = 1'b0; rack_data = $urandom;
        penable = 1'b1;
        if (wr) mem[wa] = d;
        else    exp_prdata = rv;
        chk("pready", pready, 1'b1);
        chk("pslverr", pslverr, 1'b0);
        chk("prdata", prdata, exp_prdata);
        chk("vld_drop", {wreq_vld, rreq_vld, rack_rdy}, 3'b000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_prdata", prdata, '0);
        chk("rst_vld", {wreq_vld, rreq_vld, rack_rdy}, 3'b000);
        chk("rst_addr", {rreq_addr, wreq_addr}, '0);
        chk("rst_wdata", wreq_data, '0);
        rst_n = 1'b1;

        // ---------------- directed transfers ----------------
        apb_xfer(1'b1, 18'h4, 32'h8000_0008, 0);
        idle(1);
        mem[16'h1] = 32'h9000_0000;
        apb_xfer(1'b0, 18'h4, 'x, 0);
        idle(1);
        apb_xfer(1'b1, 18'h8, 32'h1234_5678, 0);   // prdata must keep 0x9000_0000
        idle(1);
        apb_xfer(1'b1, 18'hC, 32'hA5A5_5A5A, 5);   // bank stalls the write 5 cycles
        idle(2);

`ifdef REGSPACE_BRIDGE_TIMEOUT_EN
        // ---------------- timeout on an unmapped read ----------------
        begin
            int cycles;
            @(negedge clk);
            psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 18'h40;
            @(negedge clk);
            penable = 1'b1;
            cycles = 0;
            while (rreq_vld && cycles < 40) begin
                chk("to_pready_wait", pready, 1'b0);
                cycles++;
                @(negedge clk);
            end
            chk("to_cycles", cycles, TIMEOUT);
            chk("to_pready", pready, 1'b1);
            chk("to_pslverr", pslverr, 1'b1);
            chk("to_prdata", prdata, '0);
            chk("to_vld_drop", {rreq_vld, rack_rdy}, 2'b00);
            exp_prdata = '0;
            idle(1);
            apb_xfer(1'b0, 18'h4, 'x, 1);
            idle(1);
        end
`endif

        // ---------------- reset pulsed during a pending read ----------------
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 18'h10;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("prerst_rreq_vld", rreq_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", {rreq_vld, rack_rdy}, 2'b00);
        chk("arst_pready", pready, 1'b0);
        chk("arst_prdata", prdata, '0);
        exp_prdata = '0;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        apb_xfer(1'b1, 18'h0, 32'hCAFE_F00D, 0);

        // ---------------- back-to-back write then read ----------------
        apb_xfer(1'b1, 18'h20, 32'h0BAD_BEEF, 0);
        apb_xfer(1'b0, 18'h20, 'x, 0);
        idle(1);

        // ---------------- randomized traffic ----------------
        for (int t = 0; t < 200; t++) begin
            logic [ADDR_W+1:0] a;
            a = {11'd0, 5'($urandom_range(0, 31)), 2'($urandom)};
            apb_xfer(1'($urandom % 2), a, $urandom, int'($urandom_range(0, 6)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
